// File: rtl/bam_integrated.sv
// Registered 32x32 signed multiplier: two operand registers feed a combinational
// radix-2 Booth array whose 64-bit result is captured in the product register.
module bam_integrated (
    input  logic        clk,
    input  logic        resetA,
    input  logic        resetB,
    input  logic        resetOut,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    input  logic        enableA,
    input  logic        enableB,
    input  logic        enableOut,
    output logic [63:0] Product
);

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] booth;

    always_ff @(posedge clk) begin
        if (resetA)       a_q <= '0;
        else if (enableA) a_q <= Multiplicand;
    end

    always_ff @(posedge clk) begin
        if (resetB)       b_q <= '0;
        else if (enableB) b_q <= Multiplier;
    end

    always_ff @(posedge clk) begin
        if (resetOut)       Product <= '0;
        else if (enableOut) Product <= booth;
    end

    // Upper half carried as 33 bits so subtracting -2^31 cannot overflow;
    // layout is {hi[32:0], lo[31:0], q_m1}, product sits in acc[64:1].
    always_comb begin
        logic [65:0] acc;
        logic [32:0] hi;
        logic [32:0] a_ext;
        acc   = {33'b0, b_q, 1'b0};
        hi    = '0;
        a_ext = {a_q[31], a_q};
        for (int i = 0; i < 32; i++) begin
            hi = acc[65:33];
            case (acc[1:0])
                2'b01:   hi = hi + a_ext;
                2'b10:   hi = hi - a_ext;
                default: hi = hi;
            endcase
            acc = {hi[32], hi, acc[32:1]};
        end
        booth = acc[64:1];
    end

endmodule

// File: tb/tb_bam_integrated.sv
// Directed bench for bam_integrated: hand-computed products, sign/extreme cases,
// enable/reset control behaviour.
module tb_bam_integrated;

    logic        clk = 1'b0;
    logic        resetA, resetB, resetOut;
    logic [31:0] Multiplicand, Multiplier;
    logic        enableA, enableB, enableOut;
    logic [63:0] Product;

    int total = 0;
    int bad   = 0;

    bam_integrated dut (
        .clk(clk), .resetA(resetA), .resetB(resetB), .resetOut(resetOut),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .enableA(enableA), .enableB(enableB), .enableOut(enableOut),
        .Product(Product)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic idle();
        resetA = 0; resetB = 0; resetOut = 0;
        enableA = 0; enableB = 0; enableOut = 0;
    endtask

    task automatic mul(input logic [31:0] a, input logic [31:0] b, output logic [63:0] p);
        @(negedge clk);
        idle();
        Multiplicand = a; Multiplier = b; enableA = 1; enableB = 1;
        @(negedge clk);
        idle();
        enableOut = 1;
        @(negedge clk);
        idle();
        p = Product;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        resetA = 1; resetB = 1; resetOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'h0) begin
            bad++; $display("FAIL reset_product got=%h want=%h", Product, 64'h0);
        end
        enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'h0) begin
            bad++; $display("FAIL reset_regs_zero got=%h want=%h", Product, 64'h0);
        end
    endtask

    task automatic test_basic();
        logic [31:0] av [4] = '{32'h00087234, 32'h50647236, 32'h50647236, 32'hB887CAAF};
        logic [31:0] bv [4] = '{32'h00000348, 32'h50612336, 32'hB887CAAF, 32'h887CAAF3};
        logic [63:0] ev [4] = '{64'h000000001BB6BAA0, 64'h193DE4CED7437964,
                                64'hE98E647F4142AEEA, 64'h215D8B0A7A419A1D};
        logic [63:0] p;
        for (int i = 0; i < 4; i++) begin
            mul(av[i], bv[i], p);
            total++;
            if (p !== ev[i]) begin
                bad++; $display("FAIL basic[%0d] got=%h want=%h", i, p, ev[i]);
            end
        end
    endtask

    task automatic test_sign_identity();
        logic [31:0] av [7] = '{32'h00087234, 32'hFFFFFEFD, 32'hFFFFFEFD, 32'h00000001,
                                32'hB887CAAF, 32'h00000000, 32'hB887CAAF};
        logic [31:0] bv [7] = '{32'hFFFFFEFD, 32'h00087234, 32'hFFFFFEFD, 32'h50647236,
                                32'h00000001, 32'h887CAAF3, 32'h00000000};
        logic [63:0] ev [7] = '{64'hFFFFFFFFF7747564, 64'hFFFFFFFFF7747564, 64'h0000000000010609,
                                64'h0000000050647236, 64'hFFFFFFFFB887CAAF, 64'h0, 64'h0};
        logic [63:0] p;
        for (int i = 0; i < 7; i++) begin
            mul(av[i], bv[i], p);
            total++;
            if (p !== ev[i]) begin
                bad++; $display("FAIL sign_ident[%0d] got=%h want=%h", i, p, ev[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] av [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] bv [4] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [63:0] ev [4] = '{64'h4000000000000000, 64'hC000000080000000,
                                64'h0000000000000001, 64'h3FFFFFFF00000001};
        logic [63:0] p;
        for (int i = 0; i < 4; i++) begin
            mul(av[i], bv[i], p);
            total++;
            if (p !== ev[i]) begin
                bad++; $display("FAIL extreme[%0d] got=%h want=%h", i, p, ev[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] p;
        mul(32'd6, 32'd7, p);
        @(negedge clk);
        idle();
        Multiplicand = 32'd100; Multiplier = 32'd200; enableA = 1; enableB = 1;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++;
        if (Product !== 64'd42) begin
            bad++; $display("FAIL hold got=%h want=%h", Product, 64'd42);
        end
        // Continuous enableOut re-captures the now-loaded operands.
        enableOut = 1;
        @(negedge clk);
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'd20000) begin
            bad++; $display("FAIL enout_held got=%h want=%h", Product, 64'd20000);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        mul(32'd2, 32'd3, p);
        @(negedge clk);
        idle();
        Multiplicand = 32'd5; Multiplier = 32'hFFFFFFF9; enableA = 1; enableB = 1; enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'd6) begin
            bad++; $display("FAIL same_edge_old got=%h want=%h", Product, 64'd6);
        end
        enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'hFFFFFFFFFFFFFFDD) begin
            bad++; $display("FAIL same_edge_new got=%h want=%h", Product, 64'hFFFFFFFFFFFFFFDD);
        end
    endtask

    task automatic test_resets();
        logic [63:0] p;
        mul(32'd9, 32'd11, p);
        @(negedge clk);
        idle();
        resetOut = 1; enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'h0) begin
            bad++; $display("FAIL resetout_prio got=%h want=%h", Product, 64'h0);
        end
        // resetA wins over enableA; B must survive.
        Multiplicand = 32'd77; enableA = 1; resetA = 1;
        @(negedge clk);
        idle();
        enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'h0) begin
            bad++; $display("FAIL resetA got=%h want=%h", Product, 64'h0);
        end
        Multiplicand = 32'd4; enableA = 1;
        @(negedge clk);
        idle();
        enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'd44) begin
            bad++; $display("FAIL b_kept got=%h want=%h", Product, 64'd44);
        end
        resetB = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'd44) begin
            bad++; $display("FAIL resetB_no_out got=%h want=%h", Product, 64'd44);
        end
        enableOut = 1;
        @(negedge clk);
        idle();
        total++;
        if (Product !== 64'h0) begin
            bad++; $display("FAIL resetB got=%h want=%h", Product, 64'h0);
        end
    endtask

    initial begin
        idle();
        Multiplicand = '0; Multiplier = '0;
        test_reset();
        test_basic();
        test_sign_identity();
        test_extremes();
        test_hold();
        test_back_to_back();
        test_resets();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
